// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the stopwatch sequencer.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PAUSE   = 2'd1,
        ADJ_MIN = 2'd2,
        ADJ_SEC = 2'd3
    } state_t;

    localparam logic [2:0] TENS_MAX = 3'd5;
    localparam logic [3:0] ONES_MAX = 4'd9;

    // Mode transition rule; clr is handled by the caller since it overrides everything.
    function automatic state_t next_state(
        input state_t cur,
        input logic   pause_edge,
        input logic   adj,
        input logic   sel
    );
        state_t adj_target;
        adj_target = sel ? ADJ_SEC : ADJ_MIN;
        case (cur)
            PAUSE:   next_state = pause_edge ? (adj ? adj_target : RUN) : PAUSE;
            default: next_state = pause_edge ? PAUSE : (adj ? adj_target : RUN);
        endcase
    endfunction

endpackage

// File: rtl/stopwatch_sequencer_if.sv
// Control inputs and display/status outputs of the stopwatch sequencer.
interface stopwatch_sequencer_if;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       pause;
    logic       adj;
    logic       sel;
    logic       clr;
    logic [2:0] min_tens;
    logic [3:0] min_ones;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
    logic       blink_min;
    logic       blink_sec;
    logic       paused;
    logic       wrap;

    modport master (
        output tick_1hz, tick_2hz, pause, adj, sel, clr,
        input  min_tens, min_ones, sec_tens, sec_ones,
        input  blink_min, blink_sec, paused, wrap
    );

    modport slave (
        input  tick_1hz, tick_2hz, pause, adj, sel, clr,
        output min_tens, min_ones, sec_tens, sec_ones,
        output blink_min, blink_sec, paused, wrap
    );
endinterface

// File: rtl/bcd_mod60.sv
// Two-digit BCD modulo-60 counter; carry flags the 59->00 step combinationally.
module bcd_mod60
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       inc,
    input  logic       clr,
    output logic [2:0] tens,
    output logic [3:0] ones,
    output logic       carry
);

    logic [2:0] r_tens;
    logic [3:0] r_ones;
    logic       w_ones_max;
    logic       w_tens_max;

    assign w_ones_max = (r_ones == ONES_MAX);
    assign w_tens_max = (r_tens == TENS_MAX);
    assign carry      = inc & w_ones_max & w_tens_max;
    assign tens       = r_tens;
    assign ones       = r_ones;

    // Digit-wise BCD increment so no binary value is ever held in the digits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tens <= 3'd0;
            r_ones <= 4'd0;
        end else if (clr) begin
            r_tens <= 3'd0;
            r_ones <= 4'd0;
        end else if (inc) begin
            if (w_ones_max) begin
                r_ones <= 4'd0;
                r_tens <= w_tens_max ? 3'd0 : r_tens + 3'd1;
            end else begin
                r_ones <= r_ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_sequencer.sv
// MM:SS stopwatch with run / pause / adjust-minutes / adjust-seconds modes.
//
//   state   | meaning
//   RUN     | seconds advance on tick_1hz, carry into minutes, wrap at 59:59
//   PAUSE   | time frozen; adj/sel ignored until the next pause toggle
//   ADJ_MIN | minutes advance on tick_2hz, seconds held
//   ADJ_SEC | seconds advance on tick_2hz, no carry into minutes
module stopwatch_sequencer
    import stopwatch_pkg::*;
(
    input logic                  clk,
    input logic                  reset_n,
    stopwatch_sequencer_if.slave sw
);

    state_t     r_state;
    logic       r_pause_d;
    logic       r_wrap;
    logic       r_blink_min;
    logic       r_blink_sec;
    logic       r_paused;

    state_t     w_next;
    logic       w_pause_edge;
    logic       w_sec_inc;
    logic       w_min_inc;
    logic       w_sec_carry;
    logic       w_min_carry;
    logic [2:0] w_sec_tens;
    logic [3:0] w_sec_ones;
    logic [2:0] w_min_tens;
    logic [3:0] w_min_ones;

    assign w_pause_edge = sw.pause & ~r_pause_d;
    assign w_next       = sw.clr ? RUN : next_state(r_state, w_pause_edge, sw.adj, sw.sel);

    // Ticks are qualified by the current state, so a coincident mode change does not affect them.
    assign w_sec_inc = ((r_state == RUN) & sw.tick_1hz) | ((r_state == ADJ_SEC) & sw.tick_2hz);
    assign w_min_inc = ((r_state == RUN) & sw.tick_1hz & w_sec_carry)
                     | ((r_state == ADJ_MIN) & sw.tick_2hz);

    bcd_mod60 u_sec (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_sec_inc),
        .clr     (sw.clr),
        .tens    (w_sec_tens),
        .ones    (w_sec_ones),
        .carry   (w_sec_carry)
    );

    bcd_mod60 u_min (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_min_inc),
        .clr     (sw.clr),
        .tens    (w_min_tens),
        .ones    (w_min_ones),
        .carry   (w_min_carry)
    );

    // Previous pause level; resets high so a pause held through reset release is not a toggle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_pause_d <= 1'b1;
        else          r_pause_d <= sw.pause;
    end

    // Mode FSM with registered mode indicators derived from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= RUN;
            r_blink_min <= 1'b0;
            r_blink_sec <= 1'b0;
            r_paused    <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_blink_min <= (w_next == ADJ_MIN);
            r_blink_sec <= (w_next == ADJ_SEC);
            r_paused    <= (w_next == PAUSE);
        end
    end

    // One-cycle roll-over pulse, only for the 59:59 -> 00:00 step while running.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_wrap <= 1'b0;
        else          r_wrap <= ~sw.clr & (r_state == RUN) & sw.tick_1hz & w_sec_carry & w_min_carry;
    end

    assign sw.sec_tens  = w_sec_tens;
    assign sw.sec_ones  = w_sec_ones;
    assign sw.min_tens  = w_min_tens;
    assign sw.min_ones  = w_min_ones;
    assign sw.blink_min = r_blink_min;
    assign sw.blink_sec = r_blink_sec;
    assign sw.paused    = r_paused;
    assign sw.wrap      = r_wrap;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Bench for stopwatch_sequencer: behavioural model compared every cycle, plus directed literal checks.
module tb_stopwatch_sequencer;

    localparam int M_RUN     = 0;
    localparam int M_PAUSE   = 1;
    localparam int M_ADJ_MIN = 2;
    localparam int M_ADJ_SEC = 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   errors  = 0;
    int   checks  = 0;

    // model state: time as plain integers, mode as an integer code
    int m_min  = 0;
    int m_sec  = 0;
    int m_mode = M_RUN;
    bit m_wrap = 1'b0;
    bit m_prev = 1'b1;

    int n_min, n_sec, n_mode, n_total;
    bit n_wrap, n_edge;

    stopwatch_sequencer_if sw();

    stopwatch_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sw      (sw)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // next model values from the rules, using total seconds for run-mode counting
    always_comb begin
        n_min   = m_min;
        n_sec   = m_sec;
        n_mode  = m_mode;
        n_wrap  = 1'b0;
        n_total = 0;
        n_edge  = sw.pause && !m_prev;
        if (sw.clr) begin
            n_min  = 0;
            n_sec  = 0;
            n_mode = M_RUN;
        end else begin
            if (m_mode == M_RUN && sw.tick_1hz) begin
                n_total = (m_min * 60 + m_sec + 1) % 3600;
                n_wrap  = (n_total == 0);
                n_min   = n_total / 60;
                n_sec   = n_total % 60;
            end else if (m_mode == M_ADJ_MIN && sw.tick_2hz) begin
                n_min = (m_min + 1) % 60;
            end else if (m_mode == M_ADJ_SEC && sw.tick_2hz) begin
                n_sec = (m_sec + 1) % 60;
            end
            if (n_edge)
                n_mode = (m_mode == M_PAUSE) ? (sw.adj ? (sw.sel ? M_ADJ_SEC : M_ADJ_MIN) : M_RUN)
                                             : M_PAUSE;
            else if (m_mode != M_PAUSE)
                n_mode = sw.adj ? (sw.sel ? M_ADJ_SEC : M_ADJ_MIN) : M_RUN;
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_min  <= 0;
            m_sec  <= 0;
            m_mode <= M_RUN;
            m_wrap <= 1'b0;
            m_prev <= 1'b1;
        end else begin
            m_min  <= n_min;
            m_sec  <= n_sec;
            m_mode <= n_mode;
            m_wrap <= n_wrap;
            m_prev <= sw.pause;
        end
    end

    // compare every cycle, away from the active edge
    always @(negedge clk) begin
        chk("min_tens",  int'(sw.min_tens),  m_min / 10);
        chk("min_ones",  int'(sw.min_ones),  m_min % 10);
        chk("sec_tens",  int'(sw.sec_tens),  m_sec / 10);
        chk("sec_ones",  int'(sw.sec_ones),  m_sec % 10);
        chk("wrap",      int'(sw.wrap),      int'(m_wrap));
        chk("paused",    int'(sw.paused),    int'(m_mode == M_PAUSE));
        chk("blink_min", int'(sw.blink_min), int'(m_mode == M_ADJ_MIN));
        chk("blink_sec", int'(sw.blink_sec), int'(m_mode == M_ADJ_SEC));
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic expect_time(input string name, input int mm, input int ss);
        chk({name, "_min"}, int'(sw.min_tens) * 10 + int'(sw.min_ones), mm);
        chk({name, "_sec"}, int'(sw.sec_tens) * 10 + int'(sw.sec_ones), ss);
    endtask

    task automatic expect_flags(input string name, input int p, input int bm, input int bs, input int w);
        chk({name, "_paused"},    int'(sw.paused),    p);
        chk({name, "_blink_min"}, int'(sw.blink_min), bm);
        chk({name, "_blink_sec"}, int'(sw.blink_sec), bs);
        chk({name, "_wrap"},      int'(sw.wrap),      w);
    endtask

    // load a time through the adjust modes; ends in RUN with adj=0
    task automatic set_time(input int mm, input int ss);
        sw.clr = 1'b1; step();
        sw.clr = 1'b0; sw.adj = 1'b1; sw.sel = 1'b0; step();
        repeat (mm) begin sw.tick_2hz = 1'b1; step(); sw.tick_2hz = 1'b0; step(); end
        sw.sel = 1'b1; step();
        repeat (ss) begin sw.tick_2hz = 1'b1; step(); sw.tick_2hz = 1'b0; step(); end
        sw.adj = 1'b0; step();
    endtask

    initial begin
        sw.tick_1hz = 1'b0;
        sw.tick_2hz = 1'b0;
        sw.pause    = 1'b0;
        sw.adj      = 1'b0;
        sw.sel      = 1'b0;
        sw.clr      = 1'b0;

        // reset state
        #1 reset_n = 1'b0;
        #2;
        expect_time("reset", 0, 0);
        expect_flags("reset", 0, 0, 0, 0);
        step(); step();
        #2 reset_n = 1'b1;
        step();

        // 00:58 -> 00:59 -> 01:00
        set_time(0, 58);
        expect_time("load0058", 0, 58);
        sw.tick_1hz = 1'b1; step(); sw.tick_1hz = 1'b0;
        expect_time("t0059", 0, 59);
        step();
        sw.tick_1hz = 1'b1; step(); sw.tick_1hz = 1'b0;
        expect_time("t0100", 1, 0);
        expect_flags("t0100", 0, 0, 0, 0);

        // 59:59 -> 00:00 with a single-cycle wrap
        set_time(59, 59);
        sw.tick_1hz = 1'b1; step(); sw.tick_1hz = 1'b0;
        expect_time("wrap", 0, 0);
        expect_flags("wrap_hi", 0, 0, 0, 1);
        step();
        expect_flags("wrap_lo", 0, 0, 0, 0);

        // adjust minutes with run ticks interleaved, then adjust seconds
        set_time(12, 34);
        sw.adj = 1'b1; sw.sel = 1'b0; step();
        expect_flags("adjmin", 0, 1, 0, 0);
        repeat (3) begin
            sw.tick_2hz = 1'b1; step(); sw.tick_2hz = 1'b0;
            sw.tick_1hz = 1'b1; step(); sw.tick_1hz = 1'b0;
        end
        expect_time("t1534", 15, 34);
        expect_flags("t1534", 0, 1, 0, 0);
        sw.sel = 1'b1; step();
        repeat (30) begin sw.tick_2hz = 1'b1; step(); sw.tick_2hz = 1'b0; step(); end
        expect_time("t1504", 15, 4);
        expect_flags("t1504", 0, 0, 1, 0);

        // pause from ADJ_SEC, ticks ignored, then back to RUN with adj=0
        sw.pause = 1'b1; step();
        expect_flags("pause_in", 1, 0, 0, 0);
        sw.tick_1hz = 1'b1; sw.tick_2hz = 1'b1; step(); step();
        sw.tick_1hz = 1'b0; sw.tick_2hz = 1'b0;
        expect_time("paused_hold", 15, 4);
        sw.pause = 1'b0; sw.adj = 1'b0; step();
        expect_flags("pause_stay", 1, 0, 0, 0);
        sw.pause = 1'b1; step();
        expect_flags("pause_out", 0, 0, 0, 0);
        sw.pause = 1'b0; step();

        // clr beats a coincident tick and pause edge
        set_time(7, 7);
        expect_time("load0707", 7, 7);
        sw.clr = 1'b1; sw.tick_1hz = 1'b1; sw.pause = 1'b1; step();
        sw.clr = 1'b0; sw.tick_1hz = 1'b0;
        expect_time("clr", 0, 0);
        expect_flags("clr", 0, 0, 0, 0);
        sw.pause = 1'b0; step();
        expect_flags("clr_after", 0, 0, 0, 0);

        // async reset mid-adjust with pause held high across release
        sw.adj = 1'b1; sw.sel = 1'b1; step();
        repeat (5) begin sw.tick_2hz = 1'b1; step(); sw.tick_2hz = 1'b0; step(); end
        expect_time("pre_reset", 0, 5);
        sw.pause = 1'b1; sw.adj = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        expect_time("async_rst", 0, 0);
        expect_flags("async_rst", 0, 0, 0, 0);
        step(); step();
        #2 reset_n = 1'b1;
        step();
        expect_flags("rst_rel1", 0, 0, 0, 0);
        step();
        expect_time("rst_rel2", 0, 0);
        expect_flags("rst_rel2", 0, 0, 0, 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            sw.tick_1hz = ($urandom_range(0, 2) == 0);
            sw.tick_2hz = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0)  sw.pause = ~sw.pause;
            if ($urandom_range(0, 15) == 0) sw.adj = ~sw.adj;
            if ($urandom_range(0, 7) == 0)  sw.sel = ~sw.sel;
            sw.clr = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 999) == 0) begin
                #2 reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_sequencer.md
STOPWATCH_SEQUENCER -- requirements
Module: stopwatch_sequencer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single system clock; all state SHALL update on its rising edge.
REQ-002 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-003 The block SHALL have port tick_1hz, input, 1 bit: one-cycle run-count enable pulse.
REQ-004 The block SHALL have port tick_2hz, input, 1 bit: one-cycle adjust-count enable pulse.
REQ-005 The block SHALL have port pause, input, 1 bit: debounced, synchronous level; each rising edge is one pause toggle request.
REQ-006 The block SHALL have port adj, input, 1 bit: level; 1 = adjust mode requested.
REQ-007 The block SHALL have port sel, input, 1 bit: level; 0 = adjust minutes, 1 = adjust seconds.
REQ-008 The block SHALL have port clr, input, 1 bit: synchronous clear of time and mode.
REQ-009 The block SHALL have ports min_tens, sec_tens, output, 3 bits each: BCD tens digits, range 0-5.
REQ-010 The block SHALL have ports min_ones, sec_ones, output, 4 bits each: BCD ones digits, range 0-9.
REQ-011 The block SHALL have port blink_min, output, 1 bit: 1 exactly when state is ADJ_MIN.
REQ-012 The block SHALL have port blink_sec, output, 1 bit: 1 exactly when state is ADJ_SEC.
REQ-013 The block SHALL have port paused, output, 1 bit: 1 exactly when state is PAUSE.
REQ-014 The block SHALL have port wrap, output, 1 bit: one-cycle pulse on the 59:59->00:00 roll-over in RUN.

Function
REQ-015 The FSM SHALL have four states: RUN, PAUSE, ADJ_MIN, ADJ_SEC.
REQ-016 A pause rising edge SHALL be detected against a registered copy of pause; the edge is one cycle wide.
REQ-017 On a pause edge, RUN, ADJ_MIN and ADJ_SEC SHALL go to PAUSE.
REQ-018 On a pause edge, PAUSE SHALL go to RUN if adj=0, to ADJ_MIN if adj=1 and sel=0, or to ADJ_SEC if adj=1 and sel=1.
REQ-019 Without a pause edge, RUN SHALL go to ADJ_MIN or ADJ_SEC per sel when adj=1.
REQ-020 Without a pause edge, ADJ_MIN and ADJ_SEC SHALL follow sel while adj=1 and return to RUN when adj=0.
REQ-021 In PAUSE, adj and sel SHALL be ignored; pause has priority over adj.
REQ-022 In RUN, each tick_1hz SHALL increment seconds; seconds 59 SHALL wrap to 00 and carry +1 into minutes; 59:59 SHALL become 00:00 and assert wrap.
REQ-023 In ADJ_MIN, each tick_2hz SHALL increment minutes (59->00) with seconds held and no wrap pulse.
REQ-024 In ADJ_SEC, each tick_2hz SHALL increment seconds (59->00) with no carry into minutes and no wrap pulse.
REQ-025 In PAUSE, time SHALL hold; tick_1hz in ADJ_* and tick_2hz in RUN SHALL be ignored.
REQ-026 All outputs SHALL be registered: time and wrap change the cycle after the qualifying tick; state changes the cycle after the qualifying input.
REQ-027 When a tick and a state change coincide, the tick SHALL be applied per the current (pre-transition) state.
REQ-028 clr SHALL force time to 00:00, state to RUN and wrap to 0 on the next edge; clr SHALL override ticks and pause edges in the same cycle.
REQ-029 BCD digits SHALL never leave their legal range; every increment SHALL be pure BCD with no binary intermediate exposed.

Reset
REQ-030 reset_n low SHALL immediately force state RUN, all digits 0, wrap 0, blink_min 0, blink_sec 0 and paused 0.
REQ-031 The registered pause copy SHALL reset to 1 so that pause held high through reset release produces no toggle.
REQ-032 Reset asserted mid-count or mid-adjust SHALL discard all progress; there SHALL be no partial-state retention.

Structure
REQ-033 Shared package stopwatch_pkg SHALL hold the state enum (RUN, PAUSE, ADJ_MIN, ADJ_SEC), TENS_MAX=5 and ONES_MAX=9.
REQ-034 Sub-module bcd_mod60 (inputs inc and clr; outputs tens, ones and carry on 59->00) SHALL be instantiated twice, once for seconds and once for minutes.

Verification
REQ-035 Bench SHALL cover: time 00:58, RUN, two tick_1hz -> 00:59 then 01:00.
REQ-036 Bench SHALL cover: 59:59, RUN, tick_1hz -> 00:00 with wrap high exactly one cycle.
REQ-037 Bench SHALL cover: adj=1, sel=0, time 12:34, three tick_2hz plus interleaved tick_1hz -> 15:34 with blink_min=1; then sel=1 with 30 tick_2hz -> 15:04, minutes unchanged.
REQ-038 Bench SHALL cover: pause edge in ADJ_SEC -> PAUSE, ticks ignored; pause edge with adj=0 -> RUN.
REQ-039 Bench SHALL cover: clr coincident with tick_1hz and a pause edge at 07:07 -> 00:00 in RUN.
REQ-040 Bench SHALL cover: reset_n pulsed low asynchronously mid-adjust with pause held high -> all outputs 0 and no toggle after release.
